// File: rtl/tone_sequencer.sv
// Melody sequencer: steps a synchronous note ROM at a programmable tempo and
// feeds the tone period and enable to tone_generator.
module tone_sequencer #(
  parameter int ADDR_WIDTH  = 10,
  parameter int LAST_ADDR   = 1023,
  parameter int NOTE_CYCLES = 25_000_000,
  parameter int TEMPO_STEP  = 2_500_000,
  parameter int MIN_CYCLES  = 2_500_000,
  parameter int MAX_CYCLES  = 50_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  play_pause,
  input  logic                  reverse,
  input  logic                  tempo_up,
  input  logic                  tempo_down,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [23:0]           rom_data,
  output logic [23:0]           tone_switch_period,
  output logic                  output_enable,
  output logic                  playing,
  output logic                  direction
);

  // One guard bit above MAX_CYCLES keeps tempo + TEMPO_STEP from wrapping.
  localparam int TW = $clog2(MAX_CYCLES + 1) + 1;

  localparam logic [TW-1:0]         TEMPO_RST     = TW'(NOTE_CYCLES);
  localparam logic [TW-1:0]         STEP_W        = TW'(TEMPO_STEP);
  localparam logic [TW-1:0]         MIN_W         = TW'(MIN_CYCLES);
  localparam logic [TW-1:0]         MAX_W         = TW'(MAX_CYCLES);
  localparam logic [TW-1:0]         MIN_PLUS_STEP = TW'(MIN_CYCLES + TEMPO_STEP);
  localparam logic [TW-1:0]         ONE_W         = TW'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST_A        = ADDR_WIDTH'(LAST_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ONE_A         = ADDR_WIDTH'(1);

  typedef enum logic {
    PAUSED  = 1'b0,
    PLAYING = 1'b1
  } state_t;

  state_t                  state_r;
  state_t                  state_s;
  logic [TW-1:0]           note_count_r;
  logic [TW-1:0]           note_count_s;
  logic [TW-1:0]           tempo_r;
  logic [TW-1:0]           tempo_s;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [ADDR_WIDTH-1:0]   addr_s;
  logic                    direction_r;
  logic                    direction_s;
  logic                    advance_s;
  logic                    enable_s;
  logic [23:0]             period_r;
  logic                    enable_r;
  logic                    playing_r;

  function automatic logic [ADDR_WIDTH-1:0] step_addr(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic                  rev
  );
    logic [ADDR_WIDTH-1:0] res;
    if (rev) begin
      if (addr == {ADDR_WIDTH{1'b0}}) begin
        res = LAST_A;
      end else begin
        res = addr - ONE_A;
      end
    end else begin
      if (addr == LAST_A) begin
        res = {ADDR_WIDTH{1'b0}};
      end else begin
        res = addr + ONE_A;
      end
    end
    return res;
  endfunction

  // Next-state, note timing, address stepping and saturating tempo control.
  always_comb begin
    state_s      = state_r;
    note_count_s = note_count_r;
    addr_s       = addr_r;
    direction_s  = direction_r ^ reverse;
    tempo_s      = tempo_r;
    advance_s    = 1'b0;
    enable_s     = 1'b0;

    case (state_r)
      PAUSED:  state_s = play_pause ? PLAYING : PAUSED;
      PLAYING: state_s = play_pause ? PAUSED : PLAYING;
      default: state_s = PAUSED;
    endcase

    // >= so that a tempo cut below the running count ends the note at once.
    if (state_r == PLAYING) begin
      if (note_count_r >= (tempo_r - ONE_W)) begin
        advance_s    = 1'b1;
        note_count_s = {TW{1'b0}};
      end else begin
        note_count_s = note_count_r + ONE_W;
      end
    end else begin
      note_count_s = note_count_r;
    end

    // The step uses the pre-toggle direction when reverse coincides.
    if (advance_s) begin
      addr_s = step_addr(addr_r, direction_r);
    end else begin
      addr_s = addr_r;
    end

    if (tempo_up && !tempo_down) begin
      tempo_s = (tempo_r >= MIN_PLUS_STEP) ? (tempo_r - STEP_W) : MIN_W;
    end else if (tempo_down && !tempo_up) begin
      tempo_s = ((tempo_r + STEP_W) >= MAX_W) ? MAX_W : (tempo_r + STEP_W);
    end else begin
      tempo_s = tempo_r;
    end

    if ((state_s == PLAYING) && (rom_data != 24'd0)) begin
      enable_s = 1'b1;
    end else begin
      enable_s = 1'b0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= PAUSED;
      note_count_r <= {TW{1'b0}};
      tempo_r      <= TEMPO_RST;
      addr_r       <= {ADDR_WIDTH{1'b0}};
      direction_r  <= 1'b0;
      period_r     <= 24'd0;
      enable_r     <= 1'b0;
      playing_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      note_count_r <= note_count_s;
      tempo_r      <= tempo_s;
      addr_r       <= addr_s;
      direction_r  <= direction_s;
      period_r     <= rom_data;
      enable_r     <= enable_s;
      playing_r    <= (state_s == PLAYING);
    end
  end

  assign rom_addr           = addr_r;
  assign tone_switch_period = period_r;
  assign output_enable      = enable_r;
  assign playing            = playing_r;
  assign direction          = direction_r;

endmodule
